// File: rtl/and2_event_counter.sv
// rtl/and2_event_counter.sv - windowed rise/high-cycle monitor for the registered and2 output
// Optional AND2_MON_PARITY_EN: registers even parity of the report fields onto rpt_par.
module and2_event_counter #(
  parameter int CNT_W  = 16,
  parameter int WINDOW = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_in,
  input  logic             enable,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_rise,
  output logic [CNT_W-1:0] rpt_high,
  output logic             rpt_ovf,
  output logic             rpt_par
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;

  state_t             state, state_nxt;
  logic               c_q;
  logic [WIN_W-1:0]   win_cnt;
  logic [CNT_W-1:0]   rise_acc, high_acc;
  logic               ovf;

  logic               rise;
  logic               rise_sat, high_sat;
  logic [CNT_W-1:0]   rise_nxt, high_nxt;
  logic               ovf_nxt;
  logic               last_sample;
  logic               handshake;

  assign rise        = c_in & ~c_q;
  assign rise_sat    = (rise_acc == CNT_MAX);
  assign high_sat    = (high_acc == CNT_MAX);
  assign rise_nxt    = (rise && !rise_sat) ? rise_acc + 1'b1 : rise_acc;
  assign high_nxt    = (c_in && !high_sat) ? high_acc + 1'b1 : high_acc;
  // Overflow flags an increment lost to saturation, not merely reaching the max.
  assign ovf_nxt     = ovf | (rise & rise_sat) | (c_in & high_sat);
  assign last_sample = (state == COUNT) && (win_cnt == WIN_LAST);
  assign handshake   = rpt_valid & rpt_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = COUNT;
      COUNT:   if (last_sample) state_nxt = REPORT;
      REPORT:  if (handshake) state_nxt = enable ? COUNT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q       <= 1'b0;
      win_cnt   <= '0;
      rise_acc  <= '0;
      high_acc  <= '0;
      ovf       <= 1'b0;
      rpt_valid <= 1'b0;
      rpt_rise  <= '0;
      rpt_high  <= '0;
      rpt_ovf   <= 1'b0;
    end else begin
      c_q <= c_in;
      case (state)
        IDLE: begin
          win_cnt  <= '0;
          rise_acc <= '0;
          high_acc <= '0;
          ovf      <= 1'b0;
        end
        COUNT: begin
          win_cnt  <= win_cnt + 1'b1;
          rise_acc <= rise_nxt;
          high_acc <= high_nxt;
          ovf      <= ovf_nxt;
          if (last_sample) begin
            rpt_rise  <= rise_nxt;
            rpt_high  <= high_nxt;
            rpt_ovf   <= ovf_nxt;
            rpt_valid <= 1'b1;
          end
        end
        REPORT: begin
          if (handshake) begin
            rpt_valid <= 1'b0;
            win_cnt   <= '0;
            rise_acc  <= '0;
            high_acc  <= '0;
            ovf       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AND2_MON_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           rpt_par <= 1'b0;
    else if (last_sample) rpt_par <= ^{rise_nxt, high_nxt, ovf_nxt};
  end
`else
  assign rpt_par = 1'b0;
`endif

endmodule
